// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
// Contents: opcode width, opcode enum, FSM state enum and a shift-amount width helper.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10
   } alu_op_e;

   // IDLE: output register empty, BUSY: multiply iterating, FULL: output register holds a result
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FULL
   } alu_state_e;

   function automatic int shamt_w(int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq.
// Input side: in_valid/in_ready, data_rs1, source_2, alu_inst.
// Output side: out_valid/out_ready, ALU_result and the zero/carry/overflow/negative flags.
// master = producer/consumer (bench or pipeline), slave = the ALU.
interface alu_seq_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   import alu_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] data_rs1;
   logic [DATA_WIDTH-1:0] source_2;
   logic [OP_W-1:0]       alu_inst;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] ALU_result;
   logic                  zero;
   logic                  carry;
   logic                  overflow;
   logic                  negative;

   modport master (
      output in_valid, data_rs1, source_2, alu_inst, out_ready,
      input  in_ready, out_valid, ALU_result, zero, carry, overflow, negative
   );

   modport slave (
      input  in_valid, data_rs1, source_2, alu_inst, out_ready,
      output in_ready, out_valid, ALU_result, zero, carry, overflow, negative
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports: clk, rst (sync, active-high), start (load operands), a, b,
//        done (high in the cycle before the final step edge), product (full 2*DATA_WIDTH result).
// product is the combinational next accumulator, so it is the final value while done is high.
module alu_mul_iter #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    done,
   output logic [2*DATA_WIDTH-1:0] product
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

   logic [CntW-1:0]         cnt_q;
   logic [2*DATA_WIDTH-1:0] mcand_q;
   logic [DATA_WIDTH-1:0]   mplier_q;
   logic [2*DATA_WIDTH-1:0] acc_q;
   logic [2*DATA_WIDTH-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start) begin
         cnt_q    <= CntW'(DATA_WIDTH);
         mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
      end else if (cnt_q != '0) begin
         cnt_q    <= cnt_q - CntW'(1);
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         acc_q    <= acc_d;
      end
   end

   assign done    = (cnt_q == CntW'(1));
   assign product = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU for the execute stage.
// Ports: clk, rst (sync, active-high), bus (alu_seq_if.slave: operands, opcode, result, flags,
//        valid/ready on both sides).
// Single-cycle ops land in the output register at the accept edge; MUL goes through
// alu_mul_iter and lands DATA_WIDTH edges after accept. Flags travel with the result.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4
) (
   input logic       clk,
   input logic       rst,
   alu_seq_if.slave  bus
);

   localparam int unsigned ShW = shamt_w(DATA_WIDTH);

   if ((DATA_WIDTH < 4) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : gen_bad_width
      $error("alu_seq: DATA_WIDTH must be a power of two >= 4");
   end
   if (OP_WIDTH != OP_W) begin : gen_bad_op_width
      $error("alu_seq: OP_WIDTH must be 4");
   end

   alu_state_e              state_q, state_d;
   logic [DATA_WIDTH-1:0]   a, b;
   logic [ShW-1:0]          shamt;
   logic [DATA_WIDTH:0]     add_x, sub_x;
   logic [DATA_WIDTH-1:0]   sp_res, nxt_res;
   logic                    sp_c, sp_v, nxt_c, nxt_v;
   logic                    accept, is_mul, load, mul_done;
   logic [2*DATA_WIDTH-1:0] mul_prod;
   logic [DATA_WIDTH-1:0]   result_q;
   logic                    zero_q, carry_q, overflow_q, negative_q;

   assign a      = bus.data_rs1;
   assign b      = bus.source_2;
   assign shamt  = b[ShW-1:0];
   assign add_x  = {1'b0, a} + {1'b0, b};
   // Bit DATA_WIDTH of the widened difference is the unsigned borrow
   assign sub_x  = {1'b0, a} - {1'b0, b};
   assign is_mul = (alu_op_e'(bus.alu_inst) == OP_MUL);

   assign bus.in_ready = (state_q == IDLE) || ((state_q == FULL) && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Single-cycle datapath; undefined codes fall through to ADD
   always_comb begin
      sp_res = add_x[DATA_WIDTH-1:0];
      sp_c   = add_x[DATA_WIDTH];
      sp_v   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
               (add_x[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      case (alu_op_e'(bus.alu_inst))
         OP_SUB: begin
            sp_res = sub_x[DATA_WIDTH-1:0];
            sp_c   = sub_x[DATA_WIDTH];
            sp_v   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                     (sub_x[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_AND:  begin sp_res = a & b; sp_c = 1'b0; sp_v = 1'b0; end
         OP_OR:   begin sp_res = a | b; sp_c = 1'b0; sp_v = 1'b0; end
         OP_XOR:  begin sp_res = a ^ b; sp_c = 1'b0; sp_v = 1'b0; end
         OP_SLT: begin
            sp_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            sp_c   = 1'b0;
            sp_v   = 1'b0;
         end
         OP_SLTU: begin
            sp_res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            sp_c   = 1'b0;
            sp_v   = 1'b0;
         end
         OP_SLL:  begin sp_res = a << shamt; sp_c = 1'b0; sp_v = 1'b0; end
         OP_SRL:  begin sp_res = a >> shamt; sp_c = 1'b0; sp_v = 1'b0; end
         OP_SRA:  begin sp_res = $signed(a) >>> shamt; sp_c = 1'b0; sp_v = 1'b0; end
         default: ;
      endcase
   end

   alu_mul_iter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Accept is impossible while BUSY, so the state alone selects the result source
   always_comb begin
      nxt_res = sp_res;
      nxt_c   = sp_c;
      nxt_v   = sp_v;
      if (state_q == BUSY) begin
         nxt_res = mul_prod[DATA_WIDTH-1:0];
         nxt_c   = |mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
         nxt_v   = 1'b0;
      end
   end

   assign load = (accept && !is_mul) || ((state_q == BUSY) && mul_done);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = is_mul ? BUSY : FULL;
         BUSY: if (mul_done) state_d = FULL;
         FULL: begin
            if (bus.out_ready) begin
               if (accept) state_d = is_mul ? BUSY : FULL;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            result_q   <= nxt_res;
            zero_q     <= (nxt_res == '0);
            carry_q    <= nxt_c;
            overflow_q <= nxt_v;
            negative_q <= nxt_res[DATA_WIDTH-1];
         end
      end
   end

   assign bus.out_valid  = (state_q == FULL);
   assign bus.ALU_result = result_q;
   assign bus.zero       = zero_q;
   assign bus.carry      = carry_q;
   assign bus.overflow   = overflow_q;
   assign bus.negative   = negative_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATA_WIDTH = 32).
module tb_alu_seq;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   alu_seq_if #(.DATA_WIDTH(32)) bus ();

   alu_seq #(
      .DATA_WIDTH (32),
      .OP_WIDTH   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                          input logic c, input logic v, input logic n);
      chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " result"}, bus.ALU_result, res);
      chk({tag, " flags zcvn"}, {28'd0, bus.zero, bus.carry, bus.overflow, bus.negative},
          {28'd0, z, c, v, n});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.alu_inst = op;
      bus.data_rs1 = a;
      bus.source_2 = b;
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_inst  = 4'd0;
      bus.data_rs1  = '0;
      bus.source_2  = '0;

      // Reset
      step();
      step();
      rst = 1'b0;
      chk("reset valid", 32'(bus.out_valid), 32'd0);
      chk("reset result", bus.ALU_result, 32'd0);
      chk("reset flags", {28'd0, bus.zero, bus.carry, bus.overflow, bus.negative}, 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);

      // ADD boundaries
      bus.out_ready = 1'b1;
      drive(4'd0, 32'hFFFF_FFFF, 32'd1);
      step();
      chk_out("add wrap", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(4'd0, 32'h7FFF_FFFF, 32'd1);
      step();
      chk_out("add ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);

      // Back-to-back, one result per cycle
      drive(4'd0, 32'd3, 32'd4);
      step();
      chk_out("b2b add", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'd1, 32'd5, 32'd7);
      step();
      chk_out("b2b sub", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(4'd5, 32'hFFFF_FFFF, 32'd1);
      step();
      chk_out("b2b slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'd9, 32'h8000_0000, 32'd4);
      step();
      chk_out("b2b sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(4'd6, 32'hFFFF_FFFF, 32'd1);
      step();
      chk_out("sltu", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(4'd7, 32'd1, 32'd33);
      step();
      chk_out("sll shamt mask", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'd8, 32'h8000_0000, 32'd31);
      step();
      chk_out("srl", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'd15, 32'd2, 32'd3);
      step();
      chk_out("op15 as add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(4'd1, 32'h8000_0000, 32'd1);
      step();
      chk_out("sub ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.in_valid = 1'b0;
      step();
      chk("drain to idle", 32'(bus.out_valid), 32'd0);

      // MUL: 32-cycle latency, ignores in_valid while busy
      drive(4'd10, 32'h0001_0000, 32'h0001_0000);
      step();
      chk("mul busy in_ready", 32'(bus.in_ready), 32'd0);
      drive(4'd0, 32'd1, 32'd1);
      for (int i = 1; i <= 31; i++) begin
         bus.in_valid = i[0];
         step();
         chk($sformatf("mul busy %0d valid", i), 32'(bus.out_valid), 32'd0);
         chk($sformatf("mul busy %0d in_ready", i), 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      step();
      chk_out("mul result", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Backpressure
      drive(4'd2, 32'h0F0F_0F0F, 32'h0000_00FF);
      step();
      chk_out("and", 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      drive(4'd4, 32'h0000_00AA, 32'h0000_00FF);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out($sformatf("hold %0d", i), 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("hold %0d in_ready", i), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("release in_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk_out("xor after release", 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      step();
      chk("idle after xor", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of a MUL
      drive(4'd10, 32'd3, 32'd5);
      step();
      bus.in_valid = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort valid", 32'(bus.out_valid), 32'd0);
      chk("abort result", bus.ALU_result, 32'd0);
      chk("abort in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 30; i++) begin
         step();
         chk($sformatf("abort quiet %0d", i), 32'(bus.out_valid), 32'd0);
      end
      drive(4'd3, 32'h0000_00F0, 32'h0000_000F);
      step();
      chk_out("or after abort", 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
